// File: rtl/cmd_decoder_pkg.sv
// Shared error codes, default command codes and FSM encoding for the command frame decoder.
// CMD_FRAME_CHECKSUM_EN adds the S_CSUM state.
package cmd_decoder_pkg;

    localparam logic [2:0] ERR_NONE         = 3'd0;
    localparam logic [2:0] ERR_BAD_CMD      = 3'd1;
    localparam logic [2:0] ERR_ADDR_TIMEOUT = 3'd2;
    localparam logic [2:0] ERR_DATA_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CHECKSUM     = 3'd4;

    localparam logic [7:0] CMD_WRITE_DEFAULT = 8'h00;
    localparam logic [7:0] CMD_READ_DEFAULT  = 8'h01;

    // Wide enough for up to 8 data bytes per frame.
    localparam int unsigned BYTE_CNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
`ifdef CMD_FRAME_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_e;

    function automatic logic is_frame_cmd(input logic [7:0] b, input logic [7:0] wr_code,
                                          input logic [7:0] rd_code);
        return (b == wr_code) || (b == rd_code);
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags expiry
// on the TIMEOUT_CYCLES-th one.
module cmd_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign expire = enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expire) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles a byte stream into CMD/ADDR/DATA command frames with per-byte timeout.
// Define CMD_FRAME_CHECKSUM_EN to require a trailing XOR checksum byte.
module cmd_frame_decoder
    import cmd_decoder_pkg::*;
#(
    parameter int unsigned ADDR_BYTES     = 2,
    parameter int unsigned ADDR_WIDTH     = 15,
    parameter int unsigned DATA_BYTES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 300,
    parameter logic [7:0]  CMD_WRITE      = CMD_WRITE_DEFAULT,
    parameter logic [7:0]  CMD_READ       = CMD_READ_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              i_byte,
    input  logic                    i_byte_valid,
    output logic [7:0]              o_command,
    output logic [ADDR_WIDTH-1:0]   o_address,
    output logic [8*DATA_BYTES-1:0] o_data,
    output logic                    o_readwrite,
    output logic                    o_done,
    output logic [2:0]              o_error,
    output logic                    o_busy
);

    localparam logic [BYTE_CNT_W-1:0] ADDR_LAST = BYTE_CNT_W'(ADDR_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] DATA_LAST = BYTE_CNT_W'(DATA_BYTES - 1);

    state_e                  state_q, state_d;
    logic [BYTE_CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]              command_q, command_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [8*DATA_BYTES-1:0] data_q, data_d;
    logic                    rw_q, rw_d;
    logic                    done_q, done_d;
    logic [2:0]              error_q, error_d;
`ifdef CMD_FRAME_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    logic busy;
    logic timer_clear;
    logic expire;

    assign busy        = (state_q != S_IDLE);
    assign timer_clear = i_byte_valid || !busy;

    cmd_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (timer_clear),
        .enable(busy),
        .expire(expire)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        command_d = command_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rw_d      = rw_q;
        done_d    = 1'b0;
        error_d   = error_q;
`ifdef CMD_FRAME_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_byte_valid) begin
                    command_d = i_byte;
                    rw_d      = (i_byte == CMD_READ);
                    if (is_frame_cmd(i_byte, CMD_WRITE, CMD_READ)) begin
                        state_d = S_ADDR;
                        cnt_d   = '0;
                        error_d = ERR_NONE;
                        data_d  = '0;
`ifdef CMD_FRAME_CHECKSUM_EN
                        csum_d  = i_byte;
`endif
                    end else begin
                        done_d  = 1'b1;
                        error_d = ERR_BAD_CMD;
                    end
                end
            end
            S_ADDR: begin
                if (i_byte_valid) begin
                    // Address bits beyond ADDR_WIDTH are never stored.
                    for (int i = 0; i < ADDR_WIDTH; i++) begin
                        if (cnt_q == BYTE_CNT_W'(i / 8)) addr_d[i] = i_byte[i % 8];
                    end
`ifdef CMD_FRAME_CHECKSUM_EN
                    csum_d = csum_q ^ i_byte;
`endif
                    if (cnt_q == ADDR_LAST) begin
                        cnt_d = '0;
                        if (!rw_q) begin
                            state_d = S_DATA;
                        end else begin
`ifdef CMD_FRAME_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + BYTE_CNT_W'(1);
                    end
                end else if (expire) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = ERR_ADDR_TIMEOUT;
                end
            end
            S_DATA: begin
                if (i_byte_valid) begin
                    for (int i = 0; i < 8 * DATA_BYTES; i++) begin
                        if (cnt_q == BYTE_CNT_W'(i / 8)) data_d[i] = i_byte[i % 8];
                    end
`ifdef CMD_FRAME_CHECKSUM_EN
                    csum_d = csum_q ^ i_byte;
`endif
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
`ifdef CMD_FRAME_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + BYTE_CNT_W'(1);
                    end
                end else if (expire) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = ERR_DATA_TIMEOUT;
                end
            end
`ifdef CMD_FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (i_byte_valid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = (i_byte == csum_q) ? ERR_NONE : ERR_CHECKSUM;
                end else if (expire) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = ERR_DATA_TIMEOUT;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            command_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rw_q      <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= ERR_NONE;
`ifdef CMD_FRAME_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            command_q <= command_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rw_q      <= rw_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef CMD_FRAME_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign o_command   = command_q;
    assign o_address   = addr_q;
    assign o_data      = data_q;
    assign o_readwrite = rw_q;
    assign o_done      = done_q;
    assign o_error     = error_q;
    assign o_busy      = busy;

endmodule
